md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the E stage of the P6 pipelined MIPS core, directly upstream of the M stage data memory. It owns the HI/LO registers and executes mult/multu/div/divu as multi-cycle operations with a busy flag, plus single-cycle mthi/mtlo writes. The control unit uses `start`/`busy` to stall md-class instructions in D. mfhi/mflo read `hi`/`lo` combinationally and carry the value down the E→M→W path alongside the M-stage load/store traffic.

## Interface
- MULT_CYCLES, 5: busy cycles for multiply-class ops; must be ≥1
- DIV_CYCLES, 10: busy cycles for divide-class ops; must be ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  launch multi-cycle op encoded on `md_op`; sampled at posedge
- md_op  in  4  operation select (encodings in define.v)
- a  in  32  rs operand (forwarded value)
- b  in  32  rt operand (forwarded value)
- busy  out  1  multi-cycle op in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- md_op encodings: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 no-op.
- Launch: `start`=1, `busy`=0, md_op ∈ {1–4, 7–10} → at the edge, operands are latched, the 64-bit result is computed into hidden regs `hi_p`/`lo_p`, and the counter is loaded with MULT_CYCLES (1, 2, 7–10) or DIV_CYCLES (3, 4).
- mult: {hi,lo} = signed(a)×signed(b). multu: unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divisor 0 (div/divu) → full busy period runs, HI/LO unchanged at commit.
- mthi/mtlo: md_op=5/6 with `busy`=0 → hi/lo ← a at the edge; `start` is ignored for these ops; no busy.
- `start` while `busy`=1 → ignored. mthi/mtlo while `busy`=1 → ignored. The control unit must stall so neither case occurs.
- `start` with md_op ∈ {0, 5, 6, 11–15} → no multi-cycle launch.
- Commit: the edge where counter==1 → hi←hi_p, lo←lo_p, busy→0.
- Reset: hi=0, lo=0, busy=0, counter=0, hi_p=lo_p=0. Reset mid-operation discards the pending result; there is no late commit.

## Timing
- Cycle T: start=1, op launched. Cycles T+1..T+N: busy=1, where N = MULT_CYCLES or DIV_CYCLES.
- The edge ending T+N commits. In T+N+1, busy=0 and the new hi/lo are visible.
- hi/lo keep their pre-launch values throughout T+1..T+N. An mfhi issued during busy is stalled externally.
- A back-to-back launch is legal in T+N+1.
- mthi/mtlo: latency 1; the value is visible in the cycle after the write edge.
- `busy` and `hi`/`lo` are registered outputs with no combinational path from inputs.

## Configuration
- MD_MADD_EN defined → ops 7–10 enabled, using MULT_CYCLES: madd {hi,lo} += signed product; maddu += unsigned product; msub −= signed product; msubu −= unsigned product. All arithmetic is 64-bit with wrap-around. The accumulate reads the HI/LO value at launch.
- MD_MADD_EN undefined → ops 7–10 behave as no-op: no busy, HI/LO untouched. Accumulate logic is not compiled.

## Structure
- define.v: md_op encodings (`md_none`, `md_mult`, `md_multu`, `md_div`, `md_divu`, `md_mthi`, `md_mtlo`, `md_madd`, `md_maddu`, `md_msub`, `md_msubu`) and the default cycle counts.
- One sub-module, `md_arith`: purely combinational. Takes a, b, md_op, and the current {hi,lo}; returns the 64-bit result and a `div0` flag.
- md_unit holds the counter, busy, hi_p/lo_p, and HI/LO.

## Test plan
- mult a=0xFFFFFFFF, b=2 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi a=0x1234 then mtlo a=0x5678 → hi=0x1234, lo=0x5678. divu a=7, b=0 → busy 10 cycles; hi/lo still 0x1234/0x5678.
- During mult busy cycle 2: start with div, and md_op=mthi with a=0xAAAA → both ignored; mult result commits on schedule; busy not extended.
- Reset asserted in busy cycle 3 of a div → next cycle busy=0, hi=lo=0; no commit appears afterwards.
- With MD_MADD_EN and {hi,lo}=0:5: madd a=3, b=4 → lo=17, hi=0; then msubu a=1, b=18 → {hi,lo}=0xFFFFFFFF_FFFFFFFF. Without MD_MADD_EN: same stimulus → busy stays 0 and hi/lo are unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: md_op encodings, default busy lengths and op-class helpers
// shared by md_unit and md_arith.
// Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W           = 16;

    // Ops that start a multi-cycle busy period. Accumulate ops only count
    // when the accumulate feature is built in; otherwise they are no-ops.
    function automatic logic md_is_launch(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: hit = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: hit = 1'b1;
`endif
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Divide-class ops use the longer busy period.
    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational datapath producing the 64-bit {hi,lo}
// result for mult/multu/div/divu and, with MD_MADD_EN, the accumulate ops.
// div0 flags a divide-class op with a zero divisor.
import md_unit_pkg::*;

module md_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  md_op,
`ifdef MD_MADD_EN
    input  logic [31:0] hi,
    input  logic [31:0] lo,
`endif
    output logic [63:0] result,
    output logic        div0
);

    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        div_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Product: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product are then correct for both signednesses.
    always_comb begin
        mul_signed = (md_op == MD_MULT) || (md_op == MD_MADD) || (md_op == MD_MSUB);
        ext_a      = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b      = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product    = ext_a * ext_b;
    end

    // Division on magnitudes, then sign fix-up: quotient truncates toward
    // zero, remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // as quotient 0x80000000, remainder 0 with no special case.
    always_comb begin
        div_signed = (md_op == MD_DIV);
        mag_a      = (div_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b      = (div_signed && b[31]) ? (~b + 32'd1) : b;
        div0       = md_is_div(md_op) && (b == 32'd0);
        quot_mag   = 32'd0;
        rem_mag    = 32'd0;
        if (mag_b != 32'd0) begin
            quot_mag = mag_a / mag_b;
            rem_mag  = mag_a % mag_b;
        end
        quot = (div_signed && (a[31] ^ b[31])) ? (~quot_mag + 32'd1) : quot_mag;
        rem  = (div_signed && a[31]) ? (~rem_mag + 32'd1) : rem_mag;
    end

    // Result select by op class.
    always_comb begin
        result = 64'd0;
        case (md_op)
            MD_MULT, MD_MULTU: result = product;
            MD_DIV, MD_DIVU:   result = {rem, quot};
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU: result = {hi, lo} + product;
            MD_MSUB, MD_MSUBU: result = {hi, lo} - product;
`endif
            default:           result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO. Multi-cycle ops
// compute their result at launch into hi_p/lo_p, hold busy for a fixed
// number of cycles, then commit. mthi/mtlo write directly when idle.
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu).
//
// Handshake: start is a one-cycle request sampled at posedge and accepted
// only when busy is low; the control unit stalls md-class instructions
// while busy is high, so requests seen during busy are simply dropped.
import md_unit_pkg::*;

module md_unit #(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         hi_p_q, hi_p_d;
    logic [31:0]         lo_p_q, lo_p_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0] arith_result;
    logic        arith_div0;
    logic        launch;

    md_arith u_arith (
        .a      (a),
        .b      (b),
        .md_op  (md_op),
`ifdef MD_MADD_EN
        .hi     (hi_q),
        .lo     (lo_q),
`endif
        .result (arith_result),
        .div0   (arith_div0)
    );

    // Next-state: count down and commit while busy, otherwise accept a
    // launch or an mthi/mtlo write.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        wr_en_d = wr_en_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        launch  = start && !busy_q && md_is_launch(md_op);

        if (busy_q) begin
            if (cnt_q == MD_CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                // A zero divisor runs the full period but leaves HI/LO alone.
                if (wr_en_q) begin
                    hi_d = hi_p_q;
                    lo_d = lo_p_q;
                end
            end else begin
                cnt_d = cnt_q - MD_CNT_W'(1);
            end
        end else if (launch) begin
            hi_p_d  = arith_result[63:32];
            lo_p_d  = arith_result[31:0];
            wr_en_d = !arith_div0;
            busy_d  = 1'b1;
            cnt_d   = md_is_div(md_op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end else if (md_op == MD_MTHI) begin
            hi_d = a;
        end else if (md_op == MD_MTLO) begin
            lo_d = a;
        end
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed test of md_unit against an edge-stamped reference
// model, plus hand-computed literal expectations for the listed scenarios.
module tb_md_unit;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [63:0] exp_q[$];

    md_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // HI/LO as architectural values; a launched op is remembered with the
    // edge number at which it lands. The unit is busy until that edge.
    int          edge_n = 0;
    int          m_commit_edge = 0;
    bit          m_pend_wr = 1'b0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic bit ref_launchable(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MD_MADD_EN
        if (op >= 4'd7 && op <= 4'd10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void ref_exec(input logic [3:0] op, input logic [31:0] ra,
                                     input logic [31:0] rb, input logic [63:0] acc,
                                     output logic [63:0] res, output bit wr);
        int     sa;
        int     sb;
        longint sp;
        logic [63:0] up;
        sa  = ra;
        sb  = rb;
        sp  = longint'(sa) * longint'(sb);
        up  = {32'd0, ra} * {32'd0, rb};
        res = acc;
        wr  = 1'b1;
        case (op)
            4'd1: res = sp;
            4'd2: res = up;
            4'd3: begin
                if (rb == 32'd0) wr = 1'b0;
                else begin
                    longint q;
                    longint r;
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (rb == 32'd0) wr = 1'b0;
                else res = {ra % rb, ra / rb};
            end
            4'd7:  res = acc + sp;
            4'd8:  res = acc + up;
            4'd9:  res = acc - sp;
            4'd10: res = acc - up;
            default: wr = 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (reset) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_commit_edge = 0;
            m_pend_wr = 1'b0;
        end else if (edge_n < m_commit_edge) begin
            // in flight: inputs are ignored
        end else if (edge_n == m_commit_edge) begin
            if (m_pend_wr) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (start && ref_launchable(md_op)) begin
            ref_exec(md_op, a, b, {m_hi, m_lo}, m_pend, m_pend_wr);
            m_commit_edge = edge_n + ((md_op == 4'd3 || md_op == 4'd4) ? N_DIV : N_MULT);
        end else if (md_op == 4'd5) begin
            m_hi = a;
        end else if (md_op == 4'd6) begin
            m_lo = a;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every-cycle compare of the outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_busy", {63'd0, busy}, {63'd0, (edge_n < m_commit_edge)});
            check("model_hi", {32'd0, hi}, {32'd0, m_hi});
            check("model_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    // Pop the next hand-computed {hi,lo} and compare with the outputs.
    task automatic check_hilo(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {hi, lo}, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Count busy cycles (bounded) starting at the next negedge.
    task automatic count_busy(input int already, output int n);
        n = already;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    // One-cycle start pulse, then wait for completion; returns busy length.
    task automatic run_op(input logic [3:0] op, input logic [31:0] va,
                          input logic [31:0] vb, output int n);
        @(posedge clk);
        #1 start = 1'b1; md_op = op; a = va; b = vb;
        @(posedge clk);
        #1 start = 1'b0; md_op = 4'd0;
        count_busy(0, n);
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] va);
        @(posedge clk);
        #1 start = 1'b0; md_op = op; a = va;
        @(posedge clk);
        #1 md_op = 4'd0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        @(posedge clk);
        #1 check_en = 1'b1;
        do_reset(2);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // mult -1 * 2
        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, n);
        check("mult_busy_len", n, N_MULT);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        check_hilo("mult_result");

        // multu 0xFFFFFFFF * 2
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_busy_len", n, N_MULT);
        exp_q.push_back(64'h0000_0001_FFFF_FFFE);
        check_hilo("multu_result");

        // div -7 / 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        check("div_busy_len", n, N_DIV);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        check_hilo("div_result");

        // mthi / mtlo
        write_hilo(4'd5, 32'h1234);
        write_hilo(4'd6, 32'h5678);
        exp_q.push_back(64'h0000_1234_0000_5678);
        check_hilo("mthi_mtlo");

        // divu by zero: full busy, HI/LO unchanged
        run_op(4'd4, 32'd7, 32'd0, n);
        check("divu0_busy_len", n, N_DIV);
        exp_q.push_back(64'h0000_1234_0000_5678);
        check_hilo("divu0_result");

        // overflow case of signed divide
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        exp_q.push_back(64'h0000_0000_8000_0000);
        check_hilo("div_overflow");

        // divu with remainder, signed div both negative, large signed mult
        run_op(4'd4, 32'hFFFF_FFFF, 32'd10, n);
        exp_q.push_back(64'h0000_0005_1999_9999);
        check_hilo("divu_rem");
        run_op(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, n);
        exp_q.push_back(64'hFFFF_FFFF_0000_0003);
        check_hilo("div_negneg");
        run_op(4'd1, 32'h8000_0000, 32'h8000_0000, n);
        exp_q.push_back(64'h4000_0000_0000_0000);
        check_hilo("mult_minmin");

        // start(div) and mthi during busy are ignored
        @(posedge clk);
        #1 start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0; md_op = 4'd0;
        @(posedge clk);
        #1 start = 1'b1; md_op = 4'd3; a = 32'd100; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; md_op = 4'd5; a = 32'hAAAA;
        @(posedge clk);
        #1 md_op = 4'd0;
        count_busy(3, n);
        check("ignore_busy_len", n, N_MULT);
        exp_q.push_back(64'h0000_0000_0000_000F);
        check_hilo("ignore_result");

        // reset in busy cycle 3 of a div
        write_hilo(4'd5, 32'h55);
        @(posedge clk);
        #1 start = 1'b1; md_op = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0; md_op = 4'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        repeat (15) @(negedge clk);
        check("rst_no_late_commit", {hi, lo}, 64'd0);

        // accumulate ops
        write_hilo(4'd6, 32'd5);
        run_op(4'd7, 32'd3, 32'd4, n);
`ifdef MD_MADD_EN
        check("madd_busy_len", n, N_MULT);
        exp_q.push_back(64'h0000_0000_0000_0011);
`else
        check("madd_busy_len", n, 0);
        exp_q.push_back(64'h0000_0000_0000_0005);
`endif
        check_hilo("madd_result");
        run_op(4'd10, 32'd1, 32'd18, n);
`ifdef MD_MADD_EN
        check("msubu_busy_len", n, N_MULT);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("msubu_busy_len", n, 0);
        exp_q.push_back(64'h0000_0000_0000_0005);
`endif
        check_hilo("msubu_result");

        // start with a no-op encoding does nothing
        run_op(4'd12, 32'd9, 32'd9, n);
        check("noop_busy_len", n, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
